// File: rtl/predict_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : predict_write_sequencer
// Brief    : Stroke -> recognizer -> board write sequencing, with a
//            round-robin board write port shared with mouse cell erases.
// Revision : 1.0
// ============================================================================
module predict_write_sequencer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       draw_valid,
    input  logic [3:0] draw_row,
    input  logic [3:0] draw_col,
    output logic       draw_ready,
    output logic       predict_start,
    input  logic       predict_finish,
    input  logic [3:0] predict_digit,
    input  logic       erase_req,
    input  logic [3:0] erase_row,
    input  logic [3:0] erase_col,
    output logic       erase_ready,
    output logic       wr_en,
    output logic [3:0] wr_row,
    output logic [3:0] wr_col,
    output logic [3:0] wr_data,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] reject_cnt
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_LAUNCH = 2'd1;
    localparam logic [1:0]  S_WAIT   = 2'd2;
    localparam logic [1:0]  S_COMMIT = 2'd3;
    localparam logic        c_grant_pred  = 1'b0;
    localparam logic        c_grant_erase = 1'b1;
    localparam logic [3:0]  c_max_idx     = 4'd8;
    localparam logic [19:0] c_timeout_last = 20'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state, w_next;
    logic [19:0] r_cnt;
    logic [3:0]  r_row, r_col, r_digit;
    logic [3:0]  r_erase_row, r_erase_col;
    logic        r_pred_pend, r_erase_pend, r_last_grant;
    logic [7:0]  r_reject_cnt;

    logic w_draw_accept, w_draw_ok, w_finish, w_digit_ok, w_timeout;
    logic w_erase_accept, w_grant_pred, w_grant_erase, w_reject;

    assign draw_ready     = (r_state == S_IDLE) & enable & ~r_pred_pend;
    assign erase_ready    = enable & ~r_erase_pend;
    assign w_draw_accept  = draw_valid & draw_ready;
    assign w_draw_ok      = (draw_row <= c_max_idx) && (draw_col <= c_max_idx);
    assign w_finish       = enable & (r_state == S_WAIT) & predict_finish;
    assign w_digit_ok     = (predict_digit != 4'd0) && (predict_digit <= 4'd9);
    // Finish wins over timeout when both land in the same cycle.
    assign w_timeout      = enable & (r_state == S_WAIT) & ~predict_finish
                          & (r_cnt == c_timeout_last);
    assign w_erase_accept = erase_req & erase_ready
                          & (erase_row <= c_max_idx) & (erase_col <= c_max_idx);
    assign w_grant_pred   = enable & r_pred_pend
                          & (~r_erase_pend | (r_last_grant == c_grant_erase));
    assign w_grant_erase  = enable & r_erase_pend & ~w_grant_pred;
    assign w_reject       = (w_draw_accept & ~w_draw_ok) | (w_finish & ~w_digit_ok) | w_timeout;

    assign predict_start = enable & (r_state == S_LAUNCH);
    assign timeout_err   = w_timeout;
    assign wr_en         = w_grant_pred | w_grant_erase;
    assign wr_row        = w_grant_pred ? r_row   : (w_grant_erase ? r_erase_row : 4'd0);
    assign wr_col        = w_grant_pred ? r_col   : (w_grant_erase ? r_erase_col : 4'd0);
    assign wr_data       = w_grant_pred ? r_digit : 4'd0;
    assign busy          = (r_state != S_IDLE) | r_pred_pend | r_erase_pend;
    assign reject_cnt    = r_reject_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_draw_accept & w_draw_ok) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (w_finish)       w_next = w_digit_ok ? S_COMMIT : S_IDLE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_COMMIT: if (w_grant_pred) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (!enable) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_digit      <= '0;
            r_erase_row  <= '0;
            r_erase_col  <= '0;
            r_pred_pend  <= 1'b0;
            r_erase_pend <= 1'b0;
            r_last_grant <= c_grant_erase;
            r_reject_cnt <= '0;
        end else begin
            r_state <= w_next;

            if (!enable || r_state == S_LAUNCH) r_cnt <= '0;
            else if (r_state == S_WAIT)         r_cnt <= r_cnt + 20'd1;

            if (w_draw_accept & w_draw_ok) begin
                r_row <= draw_row;
                r_col <= draw_col;
            end
            if (w_finish & w_digit_ok) r_digit <= predict_digit;
            if (w_erase_accept) begin
                r_erase_row <= erase_row;
                r_erase_col <= erase_col;
            end

            if (!enable)                    r_pred_pend <= 1'b0;
            else if (w_finish & w_digit_ok) r_pred_pend <= 1'b1;
            else if (w_grant_pred)          r_pred_pend <= 1'b0;

            if (!enable)             r_erase_pend <= 1'b0;
            else if (w_erase_accept) r_erase_pend <= 1'b1;
            else if (w_grant_erase)  r_erase_pend <= 1'b0;

            // Round-robin history only advances on contested grants.
            if (enable && r_pred_pend && r_erase_pend)
                r_last_grant <= w_grant_pred ? c_grant_pred : c_grant_erase;

            if (w_reject && r_reject_cnt != 8'hFF) r_reject_cnt <= r_reject_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_predict_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_predict_write_sequencer
// Brief    : Directed self-checking bench for predict_write_sequencer.
// Revision : 1.0
// ============================================================================
module tb_predict_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, enable, draw_valid, predict_finish, erase_req;
    logic [3:0] draw_row, draw_col, predict_digit, erase_row, erase_col;
    logic       draw_ready, predict_start, erase_ready, wr_en, busy, timeout_err;
    logic [3:0] wr_row, wr_col, wr_data;
    logic [7:0] reject_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;
    int n_start  = 0;
    int wr_snap, start_snap, lat;

    predict_write_sequencer #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .draw_valid(draw_valid), .draw_row(draw_row), .draw_col(draw_col),
        .draw_ready(draw_ready), .predict_start(predict_start),
        .predict_finish(predict_finish), .predict_digit(predict_digit),
        .erase_req(erase_req), .erase_row(erase_row), .erase_col(erase_col),
        .erase_ready(erase_ready), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .busy(busy),
        .timeout_err(timeout_err), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en)         n_wr++;
        if (predict_start) n_start++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stroke(input logic [3:0] r, input logic [3:0] c);
        draw_valid = 1'b1; draw_row = r; draw_col = c;
        tick();
        draw_valid = 1'b0;
    endtask

    task automatic finish(input logic [3:0] d);
        predict_finish = 1'b1; predict_digit = d;
        tick();
        predict_finish = 1'b0;
    endtask

    task automatic check_write(input string tag, input int r, input int c, input int d);
        check({tag, "_en"},   int'(wr_en),   1);
        check({tag, "_row"},  int'(wr_row),  r);
        check({tag, "_col"},  int'(wr_col),  c);
        check({tag, "_data"}, int'(wr_data), d);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; draw_valid = 1'b0; predict_finish = 1'b0;
        erase_req = 1'b0; draw_row = '0; draw_col = '0; predict_digit = '0;
        erase_row = '0; erase_col = '0;
        tick(3);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_row", int'(wr_row), 0);
        check("rst_reject", int'(reject_cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_draw_ready_dis", int'(draw_ready), 0);
        enable = 1'b1;
        #1;
        check("rst_draw_ready_en", int'(draw_ready), 1);
        check("rst_erase_ready_en", int'(erase_ready), 1);
        rst_n = 1'b1;
        tick();

        // Normal stroke, finish 7 cycles after start
        stroke(4'd3, 4'd5);
        check("t1_start", int'(predict_start), 1);
        check("t1_draw_ready", int'(draw_ready), 0);
        tick(7);
        check("t1_busy_wait", int'(busy), 1);
        finish(4'd4);
        check_write("t1_wr", 3, 5, 4);
        tick();
        check("t1_wr_done", int'(wr_en), 0);
        check("t1_busy", int'(busy), 0);
        check("t1_nstart", n_start, 1);
        check("t1_nwr", n_wr, 1);

        // Illegal digit, then out-of-range row
        wr_snap = n_wr;
        stroke(4'd1, 4'd1);
        tick();
        finish(4'd0);
        check("t2_busy", int'(busy), 0);
        stroke(4'd9, 4'd0);
        check("t2_no_start", int'(predict_start), 0);
        tick();
        check("t2_nwr", n_wr, wr_snap);
        check("t2_reject", int'(reject_cnt), 2);

        // Timeout
        stroke(4'd4, 4'd4);
        check("t3_start", int'(predict_start), 1);
        lat = 0;
        while (!timeout_err && lat < 40) begin
            tick();
            lat++;
        end
        check("t3_timeout_lat", lat, 16);
        tick();
        check("t3_timeout_pulse", int'(timeout_err), 0);
        check("t3_reject", int'(reject_cnt), 3);
        check("t3_busy", int'(busy), 0);
        finish(4'd5);
        tick();
        check("t3_late_nwr", n_wr, wr_snap);

        // Tie: predict wins first, then erase
        stroke(4'd6, 4'd7);
        tick();
        predict_finish = 1'b1; predict_digit = 4'd9;
        erase_req = 1'b1; erase_row = 4'd2; erase_col = 4'd2;
        tick();
        predict_finish = 1'b0; erase_req = 1'b0;
        check_write("t4a_pred", 6, 7, 9);
        check("t4a_erase_ready", int'(erase_ready), 0);
        tick();
        check_write("t4a_erase", 2, 2, 0);
        tick();
        check("t4a_idle", int'(wr_en), 0);
        check("t4a_erase_ready_back", int'(erase_ready), 1);
        // Second tie: erase wins
        stroke(4'd1, 4'd2);
        tick();
        predict_finish = 1'b1; predict_digit = 4'd3;
        erase_req = 1'b1; erase_row = 4'd8; erase_col = 4'd0;
        tick();
        predict_finish = 1'b0; erase_req = 1'b0;
        check_write("t4b_erase", 8, 0, 0);
        tick();
        check_write("t4b_pred", 1, 2, 3);
        tick();
        check("t4b_busy", int'(busy), 0);

        // Enable drop during WAIT with erase pending
        wr_snap = n_wr;
        stroke(4'd2, 4'd3);
        tick();
        erase_req = 1'b1; erase_row = 4'd4; erase_col = 4'd4;
        tick();
        erase_req = 1'b0;
        enable = 1'b0;
        #1;
        check("t5_wr_gated", int'(wr_en), 0);
        tick();
        check("t5_busy", int'(busy), 0);
        enable = 1'b1;
        #1;
        check("t5_erase_ready", int'(erase_ready), 1);
        tick(2);
        finish(4'd4);
        tick();
        check("t5_nwr", n_wr, wr_snap);
        check("t5_reject", int'(reject_cnt), 3);

        // Out-of-range erase dropped
        erase_req = 1'b1; erase_row = 4'd9; erase_col = 4'd0;
        tick();
        erase_req = 1'b0;
        check("t6_erase_drop", int'(erase_ready), 1);
        tick();
        check("t6_erase_nwr", n_wr, wr_snap);

        // Saturation and async reset mid-WAIT
        for (int i = 0; i < 300; i++) stroke(4'd9, 4'd9);
        check("t7_reject_sat", int'(reject_cnt), 255);
        stroke(4'd5, 4'd5);
        tick();
        check("t7_busy_wait", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_reject_rst", int'(reject_cnt), 0);
        check("t7_busy_rst", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        finish(4'd2);
        tick();
        check("t7_after_rst_nwr", n_wr, wr_snap);
        check("t7_after_rst_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/predict_write_sequencer.md
# predict_write_sequencer

Sequences the handwritten-digit path between the stroke-capture block, the digit-recognition engine and the sudoku board's cell-write port. It latches the target cell when a stroke completes and launches recognition. It waits for the result, with a timeout, and filters illegal digits. It then arbitrates the single board write port round-robin against cell-erase requests from the mouse.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: max cycles to wait for `predict_finish` (10 ms at 100 MHz); legal range 2..2^20-1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active low.
- `enable` in 1: game in play state; low aborts and blocks everything.
- `draw_valid` in 1: one-cycle pulse, stroke complete.
- `draw_row`, `draw_col` in 4: target cell of stroke, 0..8.
- `draw_ready` out 1: sequencer accepts `draw_valid`.
- `predict_start` out 1: one-cycle start pulse to recognizer.
- `predict_finish` in 1: one-cycle result pulse from recognizer.
- `predict_digit` in 4: recognized digit, valid with `predict_finish`.
- `erase_req` in 1: one-cycle erase pulse.
- `erase_row`, `erase_col` in 4: erase cell.
- `erase_ready` out 1: erase slot empty.
- `wr_en` out 1: one-cycle board write strobe.
- `wr_row`, `wr_col`, `wr_data` out 4: write cell and value (0 = erase).
- `busy` out 1: FSM not IDLE or any request pending.
- `timeout_err` out 1: one-cycle pulse on recognition timeout.
- `reject_cnt` out 8: saturating count of rejected strokes.

## Operation
- FSM states IDLE, LAUNCH, WAIT, COMMIT.
- IDLE: `draw_ready = enable & ~pred_pend`.
  - On `draw_valid & draw_ready`: if row ≤ 8 and col ≤ 8, latch the cell and go to LAUNCH.
  - Otherwise stay in IDLE and increment `reject_cnt`.
  - `draw_valid` while not ready is ignored and not counted.
- LAUNCH: `predict_start` = 1 for exactly this cycle; clear the timeout counter; next state WAIT.
- WAIT: the 20-bit counter increments each cycle.
  - On `predict_finish` with digit 1..9: latch the digit, set `pred_pend`, go to COMMIT.
  - On `predict_finish` with digit 0 or >9: increment `reject_cnt` and go to IDLE with no write.
  - If the counter reaches `TIMEOUT_CYCLES-1` with no finish: pulse `timeout_err`, increment `reject_cnt`, go to IDLE.
  - Finish and timeout in the same cycle: finish wins.
- COMMIT: hold until the predict write is granted, then go to IDLE.
- `predict_finish` outside WAIT is ignored.
- Erase slot: on `erase_req & erase_ready & enable` with cell ≤ 8, latch the cell and set `erase_pend`. Out-of-range cells or requests while not ready are dropped and not counted.
- Arbiter: each cycle, among `pred_pend` and `erase_pend`, grant one.
  - Both pending: grant the requester not granted last. `last_grant` resets to erase, so predict wins the first tie.
  - A grant clears that pending flag and produces a registered `wr_en` pulse with that cell and data; erase writes `wr_data` = 0.
- `reject_cnt` saturates at 255 and is cleared only by reset.
- `enable` low, synchronous: next edge forces IDLE, clears both pending flags and the counter, and forces `wr_en`, `predict_start` and `timeout_err` to 0; `reject_cnt` and `last_grant` are kept.

## Timing
- Reset values: state IDLE; pending flags 0; `last_grant` = erase; all outputs 0, including `wr_row`, `wr_col`, `wr_data` and `reject_cnt`. `draw_ready`/`erase_ready` follow `enable` after reset.
- `draw_valid` sampled at edge k → `predict_start` high in cycle k+1 → WAIT from k+2.
- `predict_finish` sampled at edge f → `pred_pend` set at f → `wr_en` high in cycle f+1 if uncontested.
- `erase_req` sampled at edge e → `wr_en` high in cycle e+1 if uncontested.
- Contested grants: back-to-back, one write per cycle; the second write follows one cycle later.
- No launch → timeout: `timeout_err` asserted TIMEOUT_CYCLES cycles after LAUNCH.
- `erase_ready` drops the cycle after acceptance and rises the cycle after its grant.
- Async reset mid-WAIT: immediate IDLE; a later `predict_finish` is ignored.

## Test plan
- Stroke at (3,5), finish 7 cycles after start with digit 4 → one `predict_start` pulse; `wr_en` once with row 3, col 5, data 4; `busy` low afterwards.
- Finish with digit 0, then a separate stroke at row 9 → no `wr_en`; `reject_cnt` = 2.
- TIMEOUT_CYCLES = 16, no finish → `timeout_err` 16 cycles after `predict_start`; `reject_cnt` +1; a late `predict_finish` produces no write.
- `predict_finish` and `erase_req` (2,2) in the same cycle after reset → predict write first, erase write (data 0) the next cycle. Repeat the tie → erase wins.
- `enable` dropped during WAIT with an erase pending → no `wr_en` ever; IDLE; pending cleared; `reject_cnt` unchanged.
- 300 rejected strokes → `reject_cnt` = 255; `rst_n` pulse → 0.
